eta2_adder_pipe_locked: RTL and testbench
=========================================

Name: eta2_adder_pipe_locked

Overview:
- Parametrised, two-stage pipelined successor to the 32-bit XOR-locked error-tolerant type-II adder.
- Generalised width and block size. Adds a runtime exact/approximate mode, a valid/ready stream handshake and a registered key load.
- Sits in the locked-netlist evaluation flow as the sequential adder core for key-sweep simulation.

Parameters:
- WIDTH, 32: operand width; result is WIDTH+1.
- BLK, 4: bits per ETA block. WIDTH % BLK == 0 is mandatory; elaboration error otherwise. NBLK = WIDTH/BLK.
- KEY_W, 2*WIDTH: key width. Fixed to 2*WIDTH; any other value is an elaboration error.
- LOCK_KEY, 64'h5A21065A09A7176D: correct key. Width KEY_W; default shown is for WIDTH=32.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- key_i  in  KEY_W  key value
- key_load_i  in  1  latch key_i into key_q on rising clk_i
- mode_i  in  1  0 = error-tolerant type-II, 1 = exact ripple; sampled with the operands
- add1_i  in  WIDTH  operand A
- add2_i  in  WIDTH  operand B
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept
- result_o  out  WIDTH+1  sum, carry in MSB
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts

Behaviour:
- Reset: key_q=0, s1_valid=0, s2_valid=0, result_o=0, valid_o=0. Stage data registers clear to 0.
- Effective mask: m = key_q ^ LOCK_KEY. When key_q == LOCK_KEY the block is functionally transparent.
- Input accept: when valid_i && ready_o.
- Stage 1 captures:
  - a' = add1_i ^ m[WIDTH-1:0], and b = add2_i;
  - mode;
  - m[KEY_W-1:WIDTH], carried with the beat;
  - per-block local carry g_j = carry-out of a'_j + b_j with carry-in 0, for j = 0..NBLK-1.
- Stage 2 computes the sum and captures result = sum ^ {1'b0, m_hi}. In-flight beats keep the mask captured at their own stage-1 entry.
- Error-tolerant mode (mode=0):
  - block j sum = a'_j + b_j + c_j;
  - c_0 = 0, and c_j = g_{j-1} for j ≥ 1; no carry chains across more than one block boundary;
  - result MSB = carry-out of block NBLK-1 including c_{NBLK-1}.
- Exact mode (mode=1): full WIDTH-bit ripple sum of a' and b, carry-out in the MSB.
- Latency: 2 cycles from accept to valid_o when there is no stall. Throughput is 1 beat per cycle.
- Handshake:
  - stage 2 advances when !s2_valid || ready_i;
  - stage 1 advances when it is empty or stage 2 advances;
  - ready_o = !s1_valid || stage-2 advance, so it depends combinationally on ready_i only;
  - result_o and valid_o are held stable while valid_o && !ready_i;
  - no beat is dropped or duplicated.
- key_load_i while beats are in flight: key_q updates next edge and affects only beats accepted after that edge.
- key_load_i in the same cycle as an accept: the accepted beat uses the old key_q.
- Reset asserted mid-operation: all in-flight beats are discarded, and valid_o deasserts asynchronously.
- Width rules: all block sums are BLK+1 bits. No sign extension; operands are unsigned.

Optional Feature:
- Macro ETA_ERR_FLAG_EN.
- Defined:
  - adds output err_o (1 bit), aligned with result_o/valid_o;
  - err_o = 1 when the mode-0 result differs from the exact sum of the same masked operands;
  - err_o = 0 in mode 1 and on reset;
  - the exact sum is computed in stage 2 in parallel.
- Undefined: no err_o port and no exact-sum logic.

Decomposition:
- Package eta_pkg holds:
  - localparam helper functions nblk(WIDTH, BLK) and blk_carry(a, b) returning the BLK+1-bit block sum;
  - the mode enum ETA_APPROX=0, ETA_EXACT=1.
- Sub-module eta_block_add: one BLK-bit adder with cin, producing sum and cout. It is instantiated NBLK times in stage 2 and reused for g_j in stage 1 with cin=0.

Test Plan:
- Correct key, mode=1, A=29AF2430, B=7A1B9ABC -> result_o=33'h0A3CABEEC two cycles after accept.
- Correct key, mode=0, A=000000FF, B=00000001:
  - result_o=33'h000000000, with err_o=1 if the feature is enabled;
  - with mode=1 the same operands give 33'h000000100.
- Key LOCK_KEY^64'h1, mode=1, A=0, B=0 -> result_o=33'h000000001. Key LOCK_KEY^(64'h1<<32) gives the same result.
- Back-to-back 16 beats with ready_i toggling 1,0,0,1 -> results in order, no loss or duplicates, and result_o stable during stalls.
- key_load_i with a different key while 2 beats are in flight -> those 2 beats use the old mask and the third beat uses the new mask.
- rst_ni pulsed low while s1 and s2 are valid -> valid_o=0 immediately, key_q=0, and the first beat after release has latency 2.

Source files
------------

// File: rtl/eta_pkg.sv
// Shared types and helpers for the locked error-tolerant type-II adder family.
package eta_pkg;

  typedef enum logic {
    ETA_APPROX = 1'b0,
    ETA_EXACT  = 1'b1
  } eta_mode_e;

  // Widest block the generic block-sum helper supports.
  localparam int unsigned BLK_MAX = 32;

  function automatic int unsigned nblk(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

  // Zero-extended block sum; callers slice the low BLK+1 bits for narrower blocks.
  function automatic logic [BLK_MAX:0] blk_carry(input logic [BLK_MAX-1:0] a,
                                                 input logic [BLK_MAX-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/eta_block_add.sv
// One BLK-bit block adder with carry-in; shared by the stage-1 local carries and stage-2 sums.
module eta_block_add #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, cin};

endmodule

// File: rtl/eta2_adder_pipe_locked.sv
// Two-stage XOR-locked ETA-II adder with exact/approximate mode and valid/ready stream ports.
// Optional err_o output (approximate result differs from exact sum) under ETA_ERR_FLAG_EN.
module eta2_adder_pipe_locked
  import eta_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     BLK      = 4,
  parameter int unsigned     KEY_W    = 2 * WIDTH,
  parameter logic [KEY_W-1:0] LOCK_KEY = KEY_W'(64'h5A21065A09A7176D)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_load_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH:0]   result_o,
  output logic             valid_o,
  input  logic             ready_i
`ifdef ETA_ERR_FLAG_EN
  ,
  output logic             err_o
`endif
);

  localparam int unsigned NBLK = nblk(WIDTH, BLK);

  if (WIDTH % BLK != 0) begin : g_bad_blk
    $error("eta2_adder_pipe_locked: WIDTH must be a multiple of BLK");
  end
  if (KEY_W != 2 * WIDTH) begin : g_bad_key
    $error("eta2_adder_pipe_locked: KEY_W must equal 2*WIDTH");
  end

  // Handshake: a beat moves across a boundary on a cycle where the sender's valid and
  // the receiver's ready are both high. Stage 2 advances when it is empty or ready_i is
  // high; stage 1 advances when empty or when stage 2 advances; ready_o mirrors stage-1
  // advance, so it depends combinationally on ready_i only. Held outputs stay stable.
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;
  logic accept;

  assign s2_adv  = !valid_o || ready_i;
  assign s1_adv  = !s1_valid || s2_adv;
  assign ready_o = s1_adv;
  assign accept  = valid_i && ready_o;

  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] mask;
  logic [WIDTH-1:0] a_m;

  assign mask = key_q ^ LOCK_KEY;
  assign a_m  = add1_i ^ mask[WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= '0;
    end else if (key_load_i) begin
      key_q <= key_i;
    end
  end

  // Stage 1: local block carries from the masked operands, carry-in 0.
  logic [NBLK-1:0] g_w;

  for (genvar j = 0; j < NBLK; j++) begin : g_local
    eta_block_add #(.BLK(BLK)) u_gen (
      .a    (a_m[j*BLK +: BLK]),
      .b    (add2_i[j*BLK +: BLK]),
      .cin  (1'b0),
      .sum  (),
      .cout (g_w[j])
    );
  end

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_mhi;
  logic [NBLK-1:0]  s1_g;
  eta_mode_e        s1_mode;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mhi   <= '0;
      s1_g     <= '0;
      s1_mode  <= ETA_APPROX;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= a_m;
        s1_b    <= add2_i;
        s1_mhi  <= mask[KEY_W-1:WIDTH];
        s1_g    <= g_w;
        s1_mode <= eta_mode_e'(mode_i);
      end
    end
  end

  // Stage 2: exact mode ripples block carry-outs; approximate mode takes only the
  // neighbouring block's local carry, so no chain spans more than one boundary.
  logic [NBLK-1:0]  cin_w;
  logic [NBLK-1:0]  cout_w;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH:0]   raw_w;

  for (genvar j = 0; j < NBLK; j++) begin : g_sum
    if (j == 0) begin : g_first
      assign cin_w[j] = 1'b0;
    end else begin : g_rest
      assign cin_w[j] = (s1_mode == ETA_EXACT) ? cout_w[j-1] : s1_g[j-1];
    end
    eta_block_add #(.BLK(BLK)) u_add (
      .a    (s1_a[j*BLK +: BLK]),
      .b    (s1_b[j*BLK +: BLK]),
      .cin  (cin_w[j]),
      .sum  (sum_w[j*BLK +: BLK]),
      .cout (cout_w[j])
    );
  end

  assign raw_w = {cout_w[NBLK-1], sum_w};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      result_o <= '0;
    end else if (s2_adv) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        result_o <= raw_w ^ {1'b0, s1_mhi};
      end
    end
  end

`ifdef ETA_ERR_FLAG_EN
  logic [WIDTH:0] exact_w;
  logic           err_d;

  assign exact_w = {1'b0, s1_a} + {1'b0, s1_b};
  assign err_d   = (s1_mode == ETA_APPROX) && (raw_w != exact_w);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      err_o <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_eta2_adder_pipe_locked.sv
// Bench for eta2_adder_pipe_locked: directed vectors, stalls, key changes, reset, random traffic.
module tb_eta2_adder_pipe_locked;

  localparam int unsigned W = 33;
  localparam logic [63:0] LOCK_KEY = 64'h5A21065A09A7176D;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] key_i = '0;
  logic        key_load_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] add1_i = '0;
  logic [31:0] add2_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [32:0] result_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
`ifdef ETA_ERR_FLAG_EN
  logic        err_o;
`endif

  eta2_adder_pipe_locked dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .key_i      (key_i),
    .key_load_i (key_load_i),
    .mode_i     (mode_i),
    .add1_i     (add1_i),
    .add2_i     (add2_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
`ifdef ETA_ERR_FLAG_EN
    ,
    .err_o      (err_o)
`endif
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  initial begin
    #3_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain block-wise arithmetic on the masked operands.
  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic mode, input logic [63:0] key,
                                          output logic err);
    logic [63:0] m;
    longint unsigned ap, bb, ex, apx, x, y, c, s;
    m   = key ^ LOCK_KEY;
    ap  = {32'b0, a ^ m[31:0]};
    bb  = {32'b0, b};
    ex  = ap + bb;
    apx = 0;
    for (int j = 0; j < 8; j++) begin
      x = (ap >> (4 * j)) & 15;
      y = (bb >> (4 * j)) & 15;
      c = 0;
      if (j > 0) c = (((ap >> (4 * (j - 1))) & 15) + ((bb >> (4 * (j - 1))) & 15)) >> 4;
      s = x + y + c;
      apx = apx | ((s & 15) << (4 * j));
      if (j == 7) apx = apx | ((s >> 4) << 32);
    end
    err = !mode && (apx != ex);
    return 33'(mode ? ex : apx) ^ {1'b0, m[63:32]};
  endfunction

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  logic [63:0]  key_model = '0;
  logic         held_valid = 1'b0;
  logic [32:0]  held_res = '0;

  always @(negedge clk_i) begin
    logic [32:0] e;
    logic        ee;
    if (!rst_ni) begin
      exp_q.delete();
      err_q.delete();
      key_model  = '0;
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("stall_valid", valid_o, 1);
        check("stall_result", result_o, held_res);
      end
      if (valid_o) begin
        if (ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 0, 1);
          end else begin
            e  = exp_q.pop_front();
            ee = err_q.pop_front();
            check("result", result_o, e);
`ifdef ETA_ERR_FLAG_EN
            check("err", err_o, ee);
`endif
          end
        end
        held_valid = !ready_i;
        held_res   = result_o;
      end else begin
        held_valid = 1'b0;
      end
      if (valid_i && ready_o) begin
        e = ref_sum(add1_i, add2_i, mode_i, key_model, ee);
        exp_q.push_back(e);
        err_q.push_back(ee);
      end
      if (key_load_i) key_model = key_i;
    end
  end

  // ready_i driver: 0 = held by tasks, 1 = random, 2 = pattern 1,0,0,1
  int ready_mode = 0;
  int pat_idx = 0;

  always @(posedge clk_i) begin
    #1;
    if (ready_mode == 1) begin
      ready_i = 1'($urandom_range(0, 1));
    end else if (ready_mode == 2) begin
      ready_i = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
      pat_idx++;
    end
  end

  // Driver tasks
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic mode);
    logic acc;
    add1_i  = a;
    add2_i  = b;
    mode_i  = mode;
    valid_i = 1'b1;
    acc     = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic load_key(input logic [63:0] k);
    key_i      = k;
    key_load_i = 1'b1;
    @(posedge clk_i);
    #1;
    key_load_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    ready_mode = 0;
    ready_i    = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
  endtask

  // Single beat into an empty pipeline with ready_i high: checks 2-cycle latency and value.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic mode, input logic [32:0] exp, input logic exp_err);
    ready_mode = 0;
    ready_i    = 1'b1;
    send_beat(a, b, mode);
    check({tag, "_lat1"}, valid_o, 0);
    @(posedge clk_i);
    #1;
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_res"}, result_o, exp);
`ifdef ETA_ERR_FLAG_EN
    check({tag, "_err"}, err_o, exp_err);
`else
    if (exp_err) begin end
`endif
    idle(1);
  endtask

  initial begin
    logic [63:0] k2;
    rst_ni = 1'b0;
    idle(3);
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_ready", ready_o, 1);
    rst_ni = 1'b1;
    idle(1);

    load_key(LOCK_KEY);
    directed("exact", 32'h29AF2430, 32'h7A1B9ABC, 1'b1, 33'h0A3CABEEC, 1'b0);
    directed("approx", 32'h000000FF, 32'h00000001, 1'b0, 33'h000000000, 1'b1);
    directed("exact_ff", 32'h000000FF, 32'h00000001, 1'b1, 33'h000000100, 1'b0);
    load_key(LOCK_KEY ^ 64'h1);
    directed("key_lo", 32'h0, 32'h0, 1'b1, 33'h000000001, 1'b0);
    load_key(LOCK_KEY ^ (64'h1 << 32));
    directed("key_hi", 32'h0, 32'h0, 1'b1, 33'h000000001, 1'b0);
    load_key(LOCK_KEY);

    // 16 back-to-back beats under a 1,0,0,1 ready pattern
    pat_idx    = 0;
    ready_mode = 2;
    for (int i = 0; i < 16; i++) send_beat($urandom, $urandom, 1'($urandom_range(0, 1)));
    drain();

    // Key change while two beats are in flight
    ready_mode = 0;
    ready_i    = 1'b0;
    send_beat($urandom, $urandom, 1'b1);
    send_beat($urandom, $urandom, 1'b0);
    k2 = {$urandom, $urandom};
    load_key(k2);
    ready_i = 1'b1;
    send_beat($urandom, $urandom, 1'b1);
    drain();

    // Reset pulse with both stages full
    load_key(LOCK_KEY);
    ready_i = 1'b0;
    send_beat($urandom, $urandom, 1'b1);
    send_beat($urandom, $urandom, 1'b1);
    check("pre_rst_valid", valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", valid_o, 0);
    check("async_rst_result", result_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    directed("post_rst", 32'h0, 32'h0, 1'b1, 33'h053861137, 1'b0);

    // Random traffic with random stalls, key loads, and loads coinciding with accepts
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: load_key(($urandom_range(0, 1) != 0) ? LOCK_KEY : {$urandom, $urandom});
        1: idle(1);
        2: begin
          key_i      = ($urandom_range(0, 1) != 0) ? LOCK_KEY : LOCK_KEY ^ (64'h1 << $urandom_range(0, 63));
          key_load_i = 1'b1;
          send_beat($urandom, $urandom, 1'($urandom_range(0, 1)));
          key_load_i = 1'b0;
        end
        default: send_beat($urandom, $urandom, 1'($urandom_range(0, 1)));
      endcase
    end
    drain();
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
